// File: rtl/expr_y_tester.sv
// Sweep driver and checker for the Y = (ab)' + cd' expression block.
// Walks abcd through all 16 vectors and tallies mismatches on y_in.
module expr_y_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_seen
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       exp_y;
  logic       miss;
  logic [4:0] err_next;

  assign exp_y    = ~(vec[3] & vec[2]) | (vec[1] & ~vec[0]);
  assign miss     = y_in ^ exp_y;
  assign err_next = err_count + {4'd0, miss};

  assign a = vec[3];
  assign b = vec[2];
  assign c = vec[1];
  assign d = vec[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (miss && !fail_seen) begin
            first_fail <= vec;
            fail_seen  <= 1'b1;
          end
          // Last vector ends the sweep; vec stays at 15 in DONE
          if (vec == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
            state <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
